// File: rtl/fpg8_pkg.sv
// Shared definitions for the CHIP-8 FX33 store-BCD path: FSM states,
// default address width and BCD digit widths.
package fpg8_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int BIN_W          = 8;
    localparam int HUND_W         = 2;
    localparam int DIGIT_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_H = 3'd1,
        ST_WR_T = 3'd2,
        ST_WR_O = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/bcd_encoder.sv
// Combinational 8-bit binary to BCD encoder (shift-and-add-3).
// Hundreds needs only 2 bits because the input never exceeds 255.
module bcd_encoder
    import fpg8_pkg::*;
(
    input  logic [BIN_W-1:0]   i_bin,
    output logic [HUND_W-1:0]  o_hundreds,
    output logic [DIGIT_W-1:0] o_tens,
    output logic [DIGIT_W-1:0] o_ones
);

    // Layout: [17:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary.
    logic [17:0] w_shift;

    // NOTE: blocking assignments are intended here; each loop pass must see
    // the previous pass's result within the same combinational evaluation.
    always_comb begin
        w_shift = {10'd0, i_bin};
        for (int i = 0; i < BIN_W; i++) begin
            if (w_shift[11:8] >= 4'd5) begin
                w_shift[11:8] = w_shift[11:8] + 4'd3;
            end
            if (w_shift[15:12] >= 4'd5) begin
                w_shift[15:12] = w_shift[15:12] + 4'd3;
            end
            w_shift = w_shift << 1;
        end
        o_hundreds = w_shift[17:16];
        o_tens     = w_shift[15:12];
        o_ones     = w_shift[11:8];
    end

endmodule

// File: rtl/bcd_store_sequencer.sv
// FX33 sequencer: latches value/I on start, then writes hundreds, tens and
// ones to I, I+1, I+2 through the arbiter's req/grant port.
module bcd_store_sequencer
    import fpg8_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_wr_req,
    input  logic                  mem_wr_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
);

    logic [HUND_W-1:0]  w_hund;
    logic [DIGIT_W-1:0] w_tens;
    logic [DIGIT_W-1:0] w_ones;

    bcd_encoder u_bcd_encoder (
        .i_bin      (value),
        .o_hundreds (w_hund),
        .o_tens     (w_tens),
        .o_ones     (w_ones)
    );

    state_t              r_state;
    state_t              w_next_state;
    logic [DIGIT_W-1:0]  r_tens,  w_next_tens;
    logic [DIGIT_W-1:0]  r_ones,  w_next_ones;
    logic [ADDR_WIDTH-1:0] r_base, w_next_base;
    logic [ADDR_WIDTH-1:0] r_addr, w_next_addr;
    logic [DATA_WIDTH-1:0] r_data, w_next_data;

    // Hundreds goes straight into r_data on start, so it needs no own register.
    // NOTE: sequential state uses non-blocking assignments only, and every
    // register (including the data path) is cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tens  <= '0;
            r_ones  <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            r_tens  <= w_next_tens;
            r_ones  <= w_next_ones;
            r_base  <= w_next_base;
            r_addr  <= w_next_addr;
            r_data  <= w_next_data;
        end
    end

    // NOTE: every signal gets a hold default before the case so that no
    // branch leaves one unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_tens  = r_tens;
        w_next_ones  = r_ones;
        w_next_base  = r_base;
        w_next_addr  = r_addr;
        w_next_data  = r_data;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_tens  = w_tens;
                    w_next_ones  = w_ones;
                    w_next_base  = base_addr;
                    w_next_addr  = base_addr;
                    w_next_data  = DATA_WIDTH'(w_hund);
                    w_next_state = ST_WR_H;
                end
            end
            ST_WR_H: begin
                if (mem_wr_grant) begin
                    w_next_addr  = r_base + ADDR_WIDTH'(1);
                    w_next_data  = DATA_WIDTH'(r_tens);
                    w_next_state = ST_WR_T;
                end
            end
            ST_WR_T: begin
                if (mem_wr_grant) begin
                    w_next_addr  = r_base + ADDR_WIDTH'(2);
                    w_next_data  = DATA_WIDTH'(r_ones);
                    w_next_state = ST_WR_O;
                end
            end
            ST_WR_O: begin
                if (mem_wr_grant) begin
                    w_next_addr  = '0;
                    w_next_data  = '0;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so reset drops them at once.
    assign mem_wr_req  = (r_state == ST_WR_H) || (r_state == ST_WR_T) ||
                         (r_state == ST_WR_O);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_data;

endmodule

// File: tb/tb_bcd_store_sequencer.sv
// Self-checking bench for bcd_store_sequencer: directed cases plus random
// operations compared against a decimal-arithmetic write-list model.
module tb_bcd_store_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  value;
    logic [11:0] base_addr;
    logic        busy;
    logic        done;
    logic        mem_wr_req;
    logic        mem_wr_grant = 1'b0;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wr_data;

    bit          grant_rand  = 1'b0;
    bit          grant_force = 1'b1;

    int          total = 0;
    int          bad   = 0;
    int          done_cnt = 0;
    logic [19:0] exp_q[$];
    logic [19:0] got_q[$];

    bcd_store_sequencer #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .value        (value),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_grant (mem_wr_grant),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data)
    );

    always #5 clk = ~clk;

    // Arbiter model: grant changes 1 time unit after the falling edge.
    always begin
        @(negedge clk);
        #1;
        mem_wr_grant = grant_rand ? 1'($urandom_range(0, 1)) : grant_force;
    end

    // Records every accepted write and every done cycle, well before the rising edge.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (mem_wr_req && mem_wr_grant) got_q.push_back({mem_addr, mem_wr_data});
            if (done) done_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: FX33 stores value/100, (value/10)%10, value%10 at I, I+1, I+2 mod 4096.
    task automatic expect_writes(input int v, input int b, input int count);
        int digits[3];
        digits[0] = v / 100;
        digits[1] = (v / 10) % 10;
        digits[2] = v % 10;
        for (int k = 0; k < count; k++) begin
            exp_q.push_back({12'((b + k) % 4096), 8'(digits[k])});
        end
    endtask

    task automatic compare_writes(input string tag, input int exp_done);
        int n;
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        end
        check({tag, "_ndone"}, done_cnt, exp_done);
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic issue_start(input int v, input int b);
        @(negedge clk);
        start     = 1'b1;
        value     = 8'(v);
        base_addr = 12'(b);
        expect_writes(v, b, 3);
    endtask

    // Waits for done with a cycle budget; optionally pokes junk starts while busy.
    task automatic wait_done(input string tag, input bit junk);
        bit seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (junk) begin
                start     = 1'($urandom_range(0, 1));
                value     = 8'($urandom);
                base_addr = 12'($urandom);
            end else begin
                start = 1'b0;
            end
            #2;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        #4;
    endtask

    task automatic run_op(input string tag, input int v, input int b);
        issue_start(v, b);
        wait_done(tag, 1'b1);
        compare_writes(tag, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        value     = '0;
        base_addr = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_req",  32'(mem_wr_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_wr_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // Latency with grant tied high, 255 @ 0x300.
        grant_rand  = 1'b0;
        grant_force = 1'b1;
        issue_start(255, 12'h300);
        #2;
        check("lat_busy_pre", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0; value = 8'($urandom); base_addr = 12'($urandom);
        #2;
        check("lat_h_req",  32'(mem_wr_req), 1);
        check("lat_h_busy", 32'(busy), 1);
        check("lat_h_addr", 32'(mem_addr), 32'h300);
        check("lat_h_data", 32'(mem_wr_data), 2);
        @(negedge clk); #2;
        check("lat_t_addr", 32'(mem_addr), 32'h301);
        check("lat_t_data", 32'(mem_wr_data), 5);
        @(negedge clk); #2;
        check("lat_o_addr", 32'(mem_addr), 32'h302);
        check("lat_o_data", 32'(mem_wr_data), 5);
        @(negedge clk); #2;
        check("lat_done",      32'(done), 1);
        check("lat_done_req",  32'(mem_wr_req), 0);
        check("lat_done_busy", 32'(busy), 1);
        @(negedge clk); #2;
        check("lat_idle_done", 32'(done), 0);
        check("lat_idle_busy", 32'(busy), 0);
        #2;
        compare_writes("lat", 1);

        run_op("v0",   0,   12'h200);
        run_op("v100", 100, 12'h200);
        run_op("v9",   9,   12'h200);
        run_op("wrap", 42,  12'hFFE);

        // Stall for 5 cycles in WR_T; address and data must hold.
        issue_start(137, 12'h400);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        grant_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("stall_req",  32'(mem_wr_req), 1);
            check("stall_addr", 32'(mem_addr), 32'h401);
            check("stall_data", 32'(mem_wr_data), 3);
            @(negedge clk);
        end
        grant_force = 1'b1;
        wait_done("stall", 1'b0);
        compare_writes("stall", 1);

        // Start while busy in WR_H, WR_O and DONE is dropped; start right after DONE is taken.
        issue_start(200, 12'h100);
        @(negedge clk); start = 1'b1; value = 8'd77; base_addr = 12'h7A0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; value = 8'd88; base_addr = 12'h7B0;
        @(negedge clk); start = 1'b1; value = 8'd99; base_addr = 12'h7C0;
        #2;
        check("ign_done", 32'(done), 1);
        issue_start(33, 12'h500);
        wait_done("ign", 1'b0);
        compare_writes("ign", 2);

        // Asynchronous reset while stalled in WR_T.
        issue_start(137, 12'h400);
        exp_q.delete();
        expect_writes(137, 12'h400, 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        grant_force = 1'b0;
        #2;
        check("ar_pre_addr", 32'(mem_addr), 32'h401);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req",  32'(mem_wr_req), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(done), 0);
        grant_force = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("ar_post_busy", 32'(busy), 0);
        compare_writes("ar", 0);
        run_op("ar_restart", 255, 12'hABC);

        // Random operations with a randomly stalling arbiter.
        grant_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            run_op($sformatf("rnd%0d", n), int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)));
        end
        grant_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
